candidate_selector: RTL
=======================

// Module: candidate_selector
// PURPOSE
//  Consumer of the hash_table query result. After a query, scans count_bus (per-window match
//  counts) one window per cycle. Streams every window whose count >= threshold over a
//  valid/ready port and reports the best-matching window (max count) plus the candidate total.
//  Sits between hash_table and the downstream alignment/reporting logic.
// PARAMETERS
//  NUM_WINDOWS       1024  entries in count_bus (max windows supported by hash_table)
//  LOG2_NUM_WINDOWS  10    index width for the scan counter
// PORTS
//  clk                      in   1     single clock, all logic rising-edge
//  reset_candidate_selector in   1     synchronous, active-high reset
//  start                    in   1     begin scan; honoured only in IDLE
//  threshold                in   32    min count to qualify; sampled at start
//  num_windows              in   32    windows to scan; sampled at start, clamped to NUM_WINDOWS
//  count_bus                in   32    [0:NUM_WINDOWS-1] unpacked array from hash_table; stable start..done
//  busy                     out  1     high from cycle after accepted start until done cycle (incl.)
//  done                     out  1     one-cycle pulse: scan finished, all candidates drained
//  cand_valid               out  1     candidate beat available
//  cand_ready               in   1     downstream accepts beat when valid&&ready
//  cand_window_id           out  32    window index of candidate
//  cand_count               out  32    its count
//  best_valid               out  1     best_count > 0
//  best_window_id           out  32    index of max count (lowest index on tie)
//  best_count               out  32    max count seen
//  num_candidates           out  32    number of windows streamed out
// BEHAVIOUR
//  - Reset (any state, incl. mid-scan): state IDLE; every output 0; cand_valid drops at once, no beat completes.
//  - FSM IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
//    IDLE: start=1 latches threshold, clamped num_windows; clears best_*/num_candidates; idx=0.
//          If clamped num_windows==0, go to DONE; else go to SCAN.
//    SCAN: advance iff output slot free (!cand_valid || cand_ready). On advance examine count_bus[idx]:
//          if count > best_count, update best_count/best_window_id (strict >, so lowest index wins ties).
//          If count >= threshold, load cand_* and set cand_valid; num_candidates++.
//          Otherwise clear cand_valid if the previous beat was accepted.
//          idx++; after examining idx==num_windows-1, go to DRAIN.
//          If the slot is not free: hold idx, cand_*, and all results.
//    DRAIN: wait until !cand_valid || cand_ready. Clear cand_valid, go to DONE.
//    DONE: done=1 for exactly one cycle, then IDLE.
//  - best_*, best_valid and num_candidates are stable from done until the next accepted start.
//  - Latency with cand_ready=1 and N windows: done is high N+2 cycles after the start cycle.
//    The start cycle is cycle 0, SCAN is cycles 1..N, DRAIN is cycle N+1, DONE is cycle N+2.
//    With num_windows=0, done is high at cycle 1.
//  - Handshake: while cand_valid && !cand_ready, cand_window_id and cand_count hold.
//    cand_valid never deasserts without acceptance, except on reset.
//  - start while busy: ignored, no effect. threshold=0: every scanned window qualifies.
//  - Counts are unsigned 32-bit; no arithmetic overflow. num_candidates <= NUM_WINDOWS.
// STRUCTURE
//  - Shared package lsh_pkg:
//    NUM_WINDOWS and LOG2_NUM_WINDOWS.
//    typedef logic [31:0] count_t; typedef logic [31:0] window_id_t.
//    enum sel_state_t {IDLE, SCAN, DRAIN, DONE}.
//  - Single module. count_bus[idx] read through a NUM_WINDOWS:1 mux indexed by the registered idx.
//    No sub-module; output register plus handshake kept inline.
// TESTING
//  1 counts[3]=5, [7]=9, rest 0; thr=5; N=16; ready=1.
//    -> beats (3,5), (7,9); best=(7,9); num_candidates=2; done at cycle 18.
//  2 Tie: counts[2]=4 and [9]=4; thr=10; N=16.
//    -> no beats; best_window_id=2, best_count=4, best_valid=1, num_candidates=0.
//  3 Backpressure: all counts=1; thr=1; N=4; ready low 3 cycles after each beat.
//    -> beats 0,1,2,3 in order with data held while stalled; done only after beat 3 is accepted.
//  4 num_windows=0, and separately num_windows=2000 (clamped to 1024).
//    -> done at cycle 1, best_valid=0; and 1024 windows scanned, done at cycle 1026.
//  5 Reset at cycle 5 of an N=16 scan with cand_valid=1.
//    -> next cycle all outputs 0, busy=0; a fresh start rescans from idx 0 correctly.
//  6 start pulsed again mid-scan, and threshold changed mid-scan.
//    -> both ignored; results match the parameters latched at the original start.

Source files
------------

// File: rtl/lsh_pkg.sv
// Shared types and sizing for the LSH candidate path.
// Window count, index width, count/id types, selector FSM states.
package lsh_pkg;

  localparam int NUM_WINDOWS      = 1024;
  localparam int LOG2_NUM_WINDOWS = 10;

  typedef logic [31:0] count_t;
  typedef logic [31:0] window_id_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } sel_state_t;

endpackage

// File: rtl/candidate_selector_if.sv
// Candidate stream bundle: valid/ready beat of (window id, count).
// master drives valid/id/count and samples ready; slave the reverse.
interface candidate_selector_if;
  import lsh_pkg::*;

  logic       cand_valid;
  logic       cand_ready;
  window_id_t cand_window_id;
  count_t     cand_count;

  modport master (
    output cand_valid,
    output cand_window_id,
    output cand_count,
    input  cand_ready
  );

  modport slave (
    input  cand_valid,
    input  cand_window_id,
    input  cand_count,
    output cand_ready
  );

endinterface

// File: rtl/candidate_selector.sv
// Scans per-window match counts one window per cycle, streams windows
// whose count >= threshold and tracks the best window and candidate total.
// Ports: clk, reset_candidate_selector (sync, active-high), start,
//  threshold, num_windows, count_bus[NUM_WINDOWS], busy, done,
//  cand (candidate stream, master), best_valid, best_window_id,
//  best_count, num_candidates.
module candidate_selector
  import lsh_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_candidate_selector,
  input  logic                 start,
  input  count_t               threshold,
  input  logic [31:0]          num_windows,
  input  count_t               count_bus [NUM_WINDOWS],
  output logic                 busy,
  output logic                 done,
  candidate_selector_if.master cand,
  output logic                 best_valid,
  output window_id_t           best_window_id,
  output count_t               best_count,
  output logic [31:0]          num_candidates
);

  localparam int IW = LOG2_NUM_WINDOWS;

  sel_state_t    state;
  sel_state_t    state_nx;
  logic [IW-1:0] idx;
  logic [IW:0]   nw_q;
  logic [IW:0]   nw_clamp;
  count_t        thr_q;
  count_t        cur;
  logic          slot_free;
  logic          last;

  // Window count needs one bit more than the index so 1024 fits.
  always_comb begin
    nw_clamp = num_windows[IW:0];
    if (num_windows > 32'(NUM_WINDOWS))
      nw_clamp = (IW+1)'(NUM_WINDOWS);
  end

  assign cur       = count_bus[idx];
  assign slot_free = !cand.cand_valid || cand.cand_ready;
  assign last      = ({1'b0, idx} == (nw_q - (IW+1)'(1)));

  always_ff @(posedge clk) begin
    if (reset_candidate_selector)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (nw_clamp == '0) ? DONE : SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (slot_free && last)
          state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (slot_free)
          state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_candidate_selector) begin
      idx                 <= '0;
      nw_q                <= '0;
      thr_q               <= '0;
      best_count          <= '0;
      best_window_id      <= '0;
      num_candidates      <= '0;
      cand.cand_valid     <= 1'b0;
      cand.cand_window_id <= '0;
      cand.cand_count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            thr_q          <= threshold;
            nw_q           <= nw_clamp;
            best_count     <= '0;
            best_window_id <= '0;
            num_candidates <= '0;
            idx            <= '0;
          end
        end
        SCAN: begin
          if (slot_free) begin
            // Strict > keeps the lowest index on ties.
            if (cur > best_count) begin
              best_count     <= cur;
              best_window_id <= window_id_t'(idx);
            end
            if (cur >= thr_q) begin
              cand.cand_valid     <= 1'b1;
              cand.cand_window_id <= window_id_t'(idx);
              cand.cand_count     <= cur;
              num_candidates      <= num_candidates + 32'd1;
            end else begin
              cand.cand_valid <= 1'b0;
            end
            idx <= idx + IW'(1);
          end
        end
        DRAIN: begin
          if (slot_free)
            cand.cand_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign best_valid = (best_count != '0);

endmodule
